mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Memory stage directly downstream of the ALU. It takes the ALU result as the effective address and the rs2 value as store data, then performs one load or store on the data-memory bus with a req/ack handshake.
- Generates byte enables and lane-replicated store data. Returns sign- or zero-extended load data.
- Flags misaligned or illegal accesses and bus timeouts.
- Holds the pipeline through `stall` while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles mem_req stays high without mem_ack before the access aborts with out_err. 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  memory op presented this cycle
- in_ready  output  1  unit can accept an op (high only in IDLE)
- in_we  input  1  1 = store, 0 = load
- in_funct3  input  3  RISC-V funct3 (width/signedness)
- in_addr  input  32  effective address (ALU result)
- in_wdata  input  32  store data (rs2)
- mem_req  output  1  bus request, held until ack or timeout
- mem_we  output  1  bus write enable
- mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated store data
- mem_rdata  input  32  read data, valid with mem_ack
- mem_ack  input  1  bus completion, single cycle
- out_valid  output  1  one-cycle completion pulse
- out_rdata  output  32  extended load data
- out_misalign  output  1  access rejected: misaligned or illegal funct3
- out_err  output  1  bus timeout
- stall  output  1  high whenever state != IDLE

Behaviour:
- Reset:
  - State goes to IDLE.
  - mem_req, mem_we, mem_addr, mem_be, mem_wdata, out_valid, out_rdata, out_misalign, out_err and the timeout counter all clear to 0.
  - in_ready = 1 and stall = 0.
- Reset mid-access: mem_req is low from the next cycle. No out_valid is produced and the op is dropped.
- FSM states are IDLE, BUS, RESP.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, latch the op.
  - If the access is illegal, go to RESP with misalign = 1. No bus cycle is issued.
  - Otherwise go to BUS. mem_req rises in the next cycle.
- Illegal access (any of these):
  - Load with funct3 in {3, 6, 7}.
  - Store with funct3 > 2.
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
- BUS:
  - mem_req = 1. mem_we, mem_addr, mem_be and mem_wdata stay stable until the state is left.
  - On mem_ack: capture and extend mem_rdata (loads only), then go to RESP.
  - The counter clears on entry and increments on each BUS cycle without ack.
  - If no ack arrives and the counter == TIMEOUT_CYCLES-1, go to RESP with err = 1. This means mem_req is high for exactly TIMEOUT_CYCLES cycles.
  - An ack in that final cycle wins over the timeout.
- RESP:
  - out_valid = 1 for one cycle together with out_rdata, out_misalign and out_err.
  - Return to IDLE.
  - Minimum latency is 3 cycles from accept to out_valid (accept, ack in first BUS cycle, RESP). The next op can be accepted in the cycle after RESP.
- Outside RESP, out_valid = 0 and out_rdata, out_misalign and out_err are 0.
- out_rdata = 0 for stores, misaligned accesses and timeouts.
- mem_ack while mem_req is low is ignored.
- Byte enables:
  - Byte access: 4'b0001 << addr[1:0].
  - Half access: 4'b0011 << {addr[1],1'b0}.
  - Word access: 4'b1111.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load data:
  - The selected lane is picked by addr[1:0].
  - LB (0) and LH (1) sign-extend.
  - LBU (4) and LHU (5) zero-extend.
  - LW (2) passes the word through.
- in_valid is ignored when in_ready = 0. Upstream holds the op, gated by stall.

Test Plan:
- SB: addr 0x0000_1003, wdata 0x0000_00AB, ack after 2 cycles -> mem_addr 0x1000, mem_be 4'b1000, mem_wdata 0xABAB_ABAB, mem_we = 1. mem_req high 2 cycles, then out_valid with out_rdata 0.
- LH: addr 0x0000_2002, mem_rdata 0x8001_1234, immediate ack -> mem_be 4'b1100, out_rdata 0xFFFF_8001, out_valid exactly 3 cycles after accept.
- LBU: addr 0x0000_3001, mem_rdata 0x0000_F000 -> out_rdata 0x0000_00F0. Repeat as LB -> out_rdata 0xFFFF_FFF0.
- LW at 0x0000_0006 and load with funct3 = 3 -> mem_req never asserts, out_valid with out_misalign = 1, out_rdata 0.
- TIMEOUT_CYCLES = 4, no ack -> mem_req high exactly 4 cycles, then out_valid with out_err = 1. With ack in the 4th cycle instead -> out_err = 0 and data is returned.
- rst asserted during the 2nd BUS cycle -> mem_req low next cycle, in_ready = 1, no out_valid. A following SW to 0x10 with ack completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory stage: issues one load or store per op on a req/ack data bus, with lane steering and load extension.
// Latency: 3 cycles accept->out_valid with immediate ack (accept, BUS, RESP); 2 cycles for rejected ops.
// Backpressure: in_ready only in IDLE, stall high otherwise; mem_req held until mem_ack or timeout.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_*                  op from the ALU stage (valid/ready, we, funct3, addr, store data)
//   mem_*                 data-memory bus (req/ack, word address, byte enables, replicated wdata, rdata)
//   out_*                 one-cycle completion: extended load data, misalign and timeout flags
//   stall                 pipeline hold while an op is in flight
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_we,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        out_valid,
    output logic [31:0] out_rdata,
    output logic        out_misalign,
    output logic        out_err,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Last counter value before the access is abandoned; unused when the timeout is disabled.
    localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] cnt_q;

    logic        illegal_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] load_d;
    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    assign in_ready = (state_q == IDLE);
    assign stall    = (state_q != IDLE);

    // Decode of the incoming op: legality, byte enables, replicated store data.
    always_comb begin
        illegal_d = 1'b0;
        if (in_we) begin
            if (in_funct3 > 3'd2) illegal_d = 1'b1;
        end else begin
            if (in_funct3 == 3'd3 || in_funct3 == 3'd6 || in_funct3 == 3'd7) illegal_d = 1'b1;
        end
        if (in_funct3[1:0] == 2'd1 && in_addr[0]) illegal_d = 1'b1;
        if (in_funct3[1:0] == 2'd2 && in_addr[1:0] != 2'd0) illegal_d = 1'b1;

        be_d    = 4'b1111;
        wdata_d = in_wdata;
        case (in_funct3[1:0])
            2'd0: begin
                be_d    = 4'b0001 << in_addr[1:0];
                wdata_d = {4{in_wdata[7:0]}};
            end
            2'd1: begin
                be_d    = 4'b0011 << {in_addr[1], 1'b0};
                wdata_d = {2{in_wdata[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = in_wdata;
            end
        endcase
    end

    // Load lane selection and extension from the latched funct3/offset.
    always_comb begin
        byte_shift = mem_rdata >> {off_q, 3'b000};
        half_shift = mem_rdata >> {off_q[1], 4'b0000};
        case (funct3_q)
            3'd0:    load_d = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'd1:    load_d = {{16{half_shift[15]}}, half_shift[15:0]};
            3'd2:    load_d = mem_rdata;
            3'd4:    load_d = {24'd0, byte_shift[7:0]};
            3'd5:    load_d = {16'd0, half_shift[15:0]};
            default: load_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            cnt_q        <= 32'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_be       <= 4'd0;
            mem_wdata    <= 32'd0;
            out_valid    <= 1'b0;
            out_rdata    <= 32'd0;
            out_misalign <= 1'b0;
            out_err      <= 1'b0;
        end else begin
            // Response outputs are only ever non-zero for the single RESP cycle.
            out_valid    <= 1'b0;
            out_rdata    <= 32'd0;
            out_misalign <= 1'b0;
            out_err      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        funct3_q  <= in_funct3;
                        off_q     <= in_addr[1:0];
                        mem_we    <= in_we;
                        mem_addr  <= {in_addr[31:2], 2'b00};
                        mem_be    <= be_d;
                        mem_wdata <= wdata_d;
                        cnt_q     <= 32'd0;
                        if (illegal_d) begin
                            // Rejected op skips the bus entirely.
                            state_q      <= RESP;
                            out_valid    <= 1'b1;
                            out_misalign <= 1'b1;
                        end else begin
                            state_q <= BUS;
                            mem_req <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    // Ack is checked first so an ack in the final cycle beats the timeout.
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        state_q   <= RESP;
                        out_valid <= 1'b1;
                        out_rdata <= mem_we ? 32'd0 : load_d;
                    end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                        mem_req   <= 1'b0;
                        state_q   <= RESP;
                        out_valid <= 1'b1;
                        out_err   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
